reg32_serializer: RTL

REG32_SERIALIZER -- requirements
Module: reg32_serializer

---
 rtl/reg32_serializer.sv | 117 +++++++++++
 1 files changed

// File: rtl/reg32_serializer.sv
// reg32_serializer: accepts a parallel word under valid/ready handshake and
// shifts it out one bit per accepted transfer, index 0 first. A new word may
// be loaded on the edge that completes the current one, giving gap-free
// back-to-back streaming. A wrapping counter records completed words.
module reg32_serializer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:WIDTH-1] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int              IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [0:WIDTH-1] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             shift_s;
    logic             at_last_s;
    logic             xfer_s;
    logic             load_acc_s;

    // Decode presentation outputs and handshake qualifiers from current state.
    always_comb begin
        shift_s    = (state_q == SHIFT);
        at_last_s  = (idx_q == LAST_IDX);
        busy       = shift_s;
        ser_valid  = shift_s;
        ser_last   = shift_s && at_last_s;
        if (shift_s) begin
            ser_out = shreg_q[idx_q];
        end else begin
            ser_out = 1'b0;
        end
        // Ready in IDLE, or on the final accepted bit so the next word chains on.
        load_ready = rst_n && (!shift_s || (ser_ready && at_last_s));
        xfer_s     = shift_s && ser_ready;
        load_acc_s = load_valid && load_ready;
        words_sent = cnt_q;
    end

    // Next-state logic: load, per-bit advance, word completion and chaining.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load_acc_s) begin
                    state_d = SHIFT;
                    shreg_d = data_in;
                    idx_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (xfer_s) begin
                    if (at_last_s) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        idx_d = {IDX_W{1'b0}};
                        if (load_acc_s) begin
                            state_d = SHIFT;
                            shreg_d = data_in;
                        end else begin
                            state_d = IDLE;
                            shreg_d = {WIDTH{1'b0}};
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = {IDX_W{1'b0}};
                shreg_d = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, index, shift register and word counter; reset aborts any word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= {IDX_W{1'b0}};
            shreg_q <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
